// File: rtl/count_evt_logger_if.sv
// rtl/count_evt_logger_if.sv - event stream bundle between the logger and its consumer
//
// Purpose: carries the head-of-FIFO event record and its valid/ready handshake.
// Signals:
//   evt_valid  logger -> consumer  head event presented
//   evt_ready  consumer -> logger  consumer accepts head event
//   evt_data   logger -> consumer  {type[1:0], count[WIDTH-1:0]}
interface count_evt_logger_if #(
   parameter int WIDTH = 4
);
   logic             evt_valid;
   logic             evt_ready;
   logic [WIDTH+1:0] evt_data;

   modport master (
      output evt_valid,
      output evt_data,
      input  evt_ready
   );

   modport slave (
      input  evt_valid,
      input  evt_data,
      output evt_ready
   );
endinterface

// File: rtl/count_evt_logger.sv
// rtl/count_evt_logger.sv - counter event detector with event FIFO, wrap counter and threshold flag
//
// Purpose: watches an upstream counter, detects MAX/ZERO rising edges and threshold
// hits, queues one event record per cycle in a small FIFO, counts wrap-arounds and
// reports whether the count is above a threshold.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   count_in        counter value from the upstream stage
//   max_count_in    upstream all-ones flag
//   zero_in         upstream zero flag
//   thresh          threshold for crossing detection / above_thresh compare
//   thresh_en       enables threshold events
//   clr             synchronous clear of FIFO, wrap_cnt, evt_overflow, prev_ok
//   evt_if          event stream (master): evt_valid, evt_data out, evt_ready in
//   evt_overflow    sticky: an event was dropped on a full FIFO
//   wrap_cnt        saturating count of wrap-arounds
//   above_thresh    registered (count_in > thresh)
module count_evt_logger #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [WIDTH-1:0]          count_in,
   input  logic                      max_count_in,
   input  logic                      zero_in,
   input  logic [WIDTH-1:0]          thresh,
   input  logic                      thresh_en,
   input  logic                      clr,
   count_evt_logger_if.master        evt_if,
   output logic                      evt_overflow,
   output logic [7:0]                wrap_cnt,
   output logic                      above_thresh
);

   localparam int AW = $clog2(DEPTH);
   localparam int DW = WIDTH + 2;
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [1:0]    TYPE_ZERO   = 2'b00;
   localparam logic [1:0]    TYPE_MAX    = 2'b01;
   localparam logic [1:0]    TYPE_THRESH = 2'b10;

   logic [WIDTH-1:0] prev_count_q, prev_count_d;
   logic             prev_max_q, prev_max_d;
   logic             prev_zero_q, prev_zero_d;
   logic             prev_ok_q, prev_ok_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      occ_q, occ_d;
   logic             overflow_q, overflow_d;
   logic [7:0]       wrap_cnt_q, wrap_cnt_d;
   logic             above_q, above_d;
   logic [DW-1:0]    mem_q [DEPTH];
   logic [DW-1:0]    mem_d [DEPTH];

   logic             max_hit, zero_hit, thr_hit, wrap_hit;
   logic             evt_hit, push, pop, full, push_ok;
   logic [1:0]       evt_type;

   // Event detection; every source is gated by prev_ok so the first sample after
   // reset/clr only seeds the history registers.
   always_comb begin
      max_hit  = prev_ok_q && max_count_in && !prev_max_q;
      zero_hit = prev_ok_q && zero_in && !prev_zero_q;
      thr_hit  = prev_ok_q && thresh_en && (count_in == thresh) && (prev_count_q != thresh);
      wrap_hit = prev_ok_q &&
                 (((prev_count_q == {WIDTH{1'b1}}) && (count_in == '0)) ||
                  ((prev_count_q == '0) && (count_in == {WIDTH{1'b1}})));
      evt_hit  = max_hit || zero_hit || thr_hit;
      // Fixed priority MAX > ZERO > THRESH; lower-priority hits are simply not recorded.
      if (max_hit) begin
         evt_type = TYPE_MAX;
      end else if (zero_hit) begin
         evt_type = TYPE_ZERO;
      end else begin
         evt_type = TYPE_THRESH;
      end
      full    = (occ_q == CNT_FULL);
      push    = !clr && evt_hit;
      pop     = !clr && (occ_q != '0) && evt_if.evt_ready;
      // A pop on the same edge frees the head slot, so a full FIFO can still accept.
      push_ok = push && (!full || pop);
   end

   always_comb begin
      prev_count_d = count_in;
      prev_max_d   = max_count_in;
      prev_zero_d  = zero_in;
      prev_ok_d    = !clr;
      above_d      = (count_in > thresh);
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      occ_d        = occ_q;
      overflow_d   = overflow_q;
      wrap_cnt_d   = wrap_cnt_q;
      mem_d        = mem_q;

      if (clr) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         occ_d      = '0;
         overflow_d = 1'b0;
         wrap_cnt_d = 8'd0;
      end else begin
         if (push_ok) begin
            mem_d[wr_ptr_q] = {evt_type, count_in};
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end
         case ({push_ok, pop})
            2'b10:   occ_d = occ_q + CNT_ONE;
            2'b01:   occ_d = occ_q - CNT_ONE;
            default: occ_d = occ_q;
         endcase
         if (push && !push_ok) begin
            overflow_d = 1'b1;
         end
         if (wrap_hit && (wrap_cnt_q != 8'hFF)) begin
            wrap_cnt_d = wrap_cnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_count_q <= '0;
         prev_max_q   <= 1'b0;
         prev_zero_q  <= 1'b0;
         prev_ok_q    <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         occ_q        <= '0;
         overflow_q   <= 1'b0;
         wrap_cnt_q   <= 8'd0;
         above_q      <= 1'b0;
      end else begin
         prev_count_q <= prev_count_d;
         prev_max_q   <= prev_max_d;
         prev_zero_q  <= prev_zero_d;
         prev_ok_q    <= prev_ok_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         occ_q        <= occ_d;
         overflow_q   <= overflow_d;
         wrap_cnt_q   <= wrap_cnt_d;
         above_q      <= above_d;
      end
   end

   // Storage needs no reset: entries are only visible while occupancy covers them.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign evt_if.evt_valid = (occ_q != '0);
   assign evt_if.evt_data  = (occ_q != '0) ? mem_q[rd_ptr_q] : '0;
   assign evt_overflow     = overflow_q;
   assign wrap_cnt         = wrap_cnt_q;
   assign above_thresh     = above_q;

endmodule

// File: tb/tb_count_evt_logger.sv
// tb/tb_count_evt_logger.sv - self-checking bench for count_evt_logger
//
// Purpose: directed scenarios plus randomized traffic, compared every cycle against
// a queue-based reference model of the event logger.
// Ports: none (top-level bench).
module tb_count_evt_logger;
   localparam int WIDTH = 4;
   localparam int DEPTH = 4;
   localparam int MAXV  = (1 << WIDTH) - 1;

   logic             clk = 1'b0;
   logic             rst;
   logic [WIDTH-1:0] count_in;
   logic             max_count_in;
   logic             zero_in;
   logic [WIDTH-1:0] thresh;
   logic             thresh_en;
   logic             clr;
   logic             evt_overflow;
   logic [7:0]       wrap_cnt;
   logic             above_thresh;

   count_evt_logger_if #(.WIDTH(WIDTH)) evt_if ();

   count_evt_logger #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .count_in     (count_in),
      .max_count_in (max_count_in),
      .zero_in      (zero_in),
      .thresh       (thresh),
      .thresh_en    (thresh_en),
      .clr          (clr),
      .evt_if       (evt_if),
      .evt_overflow (evt_overflow),
      .wrap_cnt     (wrap_cnt),
      .above_thresh (above_thresh)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state
   int m_q[$];
   bit m_ovf;
   int m_wrap;
   bit m_above;
   int m_pc;
   bit m_pmax;
   bit m_pzero;
   bit m_pok;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, "_valid"}, 32'(evt_if.evt_valid), 32'(m_q.size() != 0));
      if (m_q.size() != 0) chk({tag, "_data"}, 32'(evt_if.evt_data), 32'(m_q[0]));
      chk({tag, "_ovf"}, 32'(evt_overflow), 32'(m_ovf));
      chk({tag, "_wrap"}, 32'(wrap_cnt), 32'(m_wrap));
      chk({tag, "_above"}, 32'(above_thresh), 32'(m_above));
   endtask

   task automatic model_reset();
      m_q.delete();
      m_ovf = 0; m_wrap = 0; m_above = 0;
      m_pc = 0; m_pmax = 0; m_pzero = 0; m_pok = 0;
   endtask

   // One clock edge worth of behaviour, written from the event/FIFO rules.
   task automatic model_step(input int c, input int th, input bit ten, input bit rdy, input bit cl);
      int ev;
      bit pop;
      if (cl) begin
         m_q.delete();
         m_ovf = 0;
         m_wrap = 0;
         m_pok = 0;
      end else begin
         pop = (m_q.size() > 0) && rdy;
         ev = -1;
         if (m_pok) begin
            if (c == MAXV && !m_pmax)                    ev = (1 << WIDTH) | c;
            else if (c == 0 && !m_pzero)                 ev = c;
            else if (ten && c == th && m_pc != th)       ev = (2 << WIDTH) | c;
            if ((m_pc == MAXV && c == 0) || (m_pc == 0 && c == MAXV))
               if (m_wrap < 255) m_wrap++;
         end
         if (pop) void'(m_q.pop_front());
         if (ev >= 0) begin
            if (m_q.size() < DEPTH) m_q.push_back(ev);
            else m_ovf = 1;
         end
         m_pok = 1;
      end
      m_above = (c > th);
      m_pc    = c;
      m_pmax  = (c == MAXV);
      m_pzero = (c == 0);
   endtask

   // Called at a falling edge: drive, advance model, clock, check at next falling edge.
   task automatic cyc(input int c, input int th, input bit ten, input bit rdy, input bit cl);
      count_in         = WIDTH'(c);
      max_count_in     = (c == MAXV);
      zero_in          = (c == 0);
      thresh           = WIDTH'(th);
      thresh_en        = ten;
      evt_if.evt_ready = rdy;
      clr              = cl;
      model_step(c, th, ten, rdy, cl);
      @(posedge clk);
      @(negedge clk);
      check_all("cyc");
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      chk("rst_valid", 32'(evt_if.evt_valid), 32'd0);
      chk("rst_data", 32'(evt_if.evt_data), 32'd0);
      chk("rst_ovf", 32'(evt_overflow), 32'd0);
      chk("rst_wrap", 32'(wrap_cnt), 32'd0);
      chk("rst_above", 32'(above_thresh), 32'd0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int c;
      int th;
      rst = 1'b1;
      count_in = '0; max_count_in = 1'b0; zero_in = 1'b1;
      thresh = '0; thresh_en = 1'b0; clr = 1'b0; evt_if.evt_ready = 1'b0;
      @(negedge clk);
      do_reset();

      // Reset release with zero held, then 0->1: no events.
      cyc(0, 9, 0, 0, 0);
      chk("r035_a", 32'(evt_if.evt_valid), 32'd0);
      cyc(1, 9, 0, 0, 0);
      chk("r035_b", 32'(evt_if.evt_valid), 32'd0);

      // MAX edge then 15->0 wrap with ZERO event.
      cyc(14, 0, 0, 0, 1);
      cyc(14, 0, 0, 0, 0);
      cyc(14, 0, 0, 0, 0);
      cyc(15, 0, 0, 0, 0);
      chk("r036_valid", 32'(evt_if.evt_valid), 32'd1);
      chk("r036_data", 32'(evt_if.evt_data), 32'b01_1111);
      cyc(0, 0, 0, 0, 0);
      chk("r036_wrap", 32'(wrap_cnt), 32'd1);
      cyc(0, 0, 0, 1, 0);
      chk("r036_second", 32'(evt_if.evt_data), 32'b00_0000);
      cyc(0, 0, 0, 1, 0);

      // Threshold crossing 3,4,5,5,6.
      cyc(3, 5, 1, 0, 1);
      cyc(3, 5, 1, 0, 0);
      cyc(4, 5, 1, 0, 0);
      cyc(5, 5, 1, 0, 0);
      cyc(5, 5, 1, 0, 0);
      cyc(6, 5, 1, 0, 0);
      chk("r037_data", 32'(evt_if.evt_data), 32'b10_0101);
      chk("r037_above", 32'(above_thresh), 32'd1);
      cyc(6, 5, 1, 1, 0);
      chk("r037_single", 32'(evt_if.evt_valid), 32'd0);

      // Five events into a four-deep FIFO, then drain.
      cyc(5, 8, 0, 0, 1);
      cyc(5, 8, 0, 0, 0);
      cyc(15, 8, 0, 0, 0);
      cyc(0, 8, 0, 0, 0);
      cyc(15, 8, 0, 0, 0);
      cyc(0, 8, 0, 0, 0);
      cyc(15, 8, 0, 0, 0);
      chk("r038_ovf", 32'(evt_overflow), 32'd1);
      for (int i = 0; i < 5; i++) cyc(15, 8, 0, 1, 0);
      chk("r038_empty", 32'(evt_if.evt_valid), 32'd0);

      // Full FIFO with simultaneous push and pop.
      cyc(5, 8, 0, 0, 1);
      cyc(5, 8, 0, 0, 0);
      cyc(15, 8, 0, 0, 0);
      cyc(0, 8, 0, 0, 0);
      cyc(15, 8, 0, 0, 0);
      cyc(0, 8, 0, 0, 0);
      cyc(15, 8, 0, 1, 0);
      chk("r039_ovf", 32'(evt_overflow), 32'd0);
      cyc(15, 8, 0, 0, 0);
      for (int i = 0; i < 5; i++) cyc(15, 8, 0, 1, 0);

      // Wrap saturation, then clear.
      cyc(0, 8, 0, 1, 1);
      cyc(0, 8, 0, 1, 0);
      for (int i = 0; i < 300; i++) cyc((i % 2 == 0) ? 15 : 0, 8, 0, 1, 0);
      chk("r040_sat", 32'(wrap_cnt), 32'd255);
      cyc(0, 8, 0, 0, 1);
      chk("r040_clr_wrap", 32'(wrap_cnt), 32'd0);
      chk("r040_clr_valid", 32'(evt_if.evt_valid), 32'd0);

      // Mid-operation reset discards queue; first post-reset sample at MAX is silent.
      cyc(3, 8, 0, 0, 0);
      cyc(15, 8, 0, 0, 0);
      cyc(0, 8, 0, 0, 0);
      do_reset();
      cyc(15, 8, 0, 0, 0);
      chk("r034_silent", 32'(evt_if.evt_valid), 32'd0);

      // Randomized traffic.
      th = 7;
      for (int i = 0; i < 1500; i++) begin
         if (i % 64 == 0) th = int'($urandom_range(0, MAXV));
         case ($urandom_range(0, 3))
            0: c = 0;
            1: c = MAXV;
            2: c = th;
            default: c = int'($urandom_range(0, MAXV));
         endcase
         cyc(c, th, bit'($urandom_range(0, 1)),
             ((i / 128) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 63) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
